// File: rtl/scroll_msg_buffer.sv
// Message store plus scrolling 4-character window, decoded to active-low
// seven-segment patterns for the rolling digit driver.
module scroll_msg_buffer #(
  parameter int ADDR_W   = 4,
  parameter int TICK_MAX = 100000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [4:0]        wr_char,
  input  logic              len_we,
  input  logic [ADDR_W:0]   len_in,
  input  logic              run,
  output logic [27:0]       seg_bus,
  output logic [ADDR_W-1:0] pos,
  output logic              scroll_tick
);

  localparam int MSG_DEPTH = 1 << ADDR_W;
  localparam int CNT_W     = (TICK_MAX > 2) ? $clog2(TICK_MAX) : 1;
  localparam logic [ADDR_W:0] LEN_MAX  = (ADDR_W+1)'(MSG_DEPTH);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(TICK_MAX - 1);

  logic [4:0]        mem [MSG_DEPTH];
  logic [ADDR_W:0]   msg_len;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] idx1, idx2, idx3;

  function automatic logic [6:0] decode(input logic [4:0] code);
    logic [6:0] s;
    case (code)
      5'h00: s = 7'b1000000;
      5'h01: s = 7'b1111001;
      5'h02: s = 7'b0100100;
      5'h03: s = 7'b0110000;
      5'h04: s = 7'b0011001;
      5'h05: s = 7'b0010010;
      5'h06: s = 7'b0000010;
      5'h07: s = 7'b1111000;
      5'h08: s = 7'b0000000;
      5'h09: s = 7'b0010000;
      5'h0A: s = 7'b0001000;
      5'h0B: s = 7'b0000011;
      5'h0C: s = 7'b1000110;
      5'h0D: s = 7'b0100001;
      5'h0E: s = 7'b0000110;
      5'h0F: s = 7'b0001110;
      5'h11: s = 7'b1000111;
      5'h12: s = 7'b1000001;
      5'h13: s = 7'b0001001;
      5'h14: s = 7'b0001100;
      5'h15: s = 7'b0111111;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Increment-and-wrap at the message length; chaining it keeps short
  // messages (length 1..3) repeating across the window.
  function automatic logic [ADDR_W-1:0] next_idx(input logic [ADDR_W-1:0] i,
                                                 input logic [ADDR_W:0]   len);
    logic [ADDR_W-1:0] inc;
    inc = i + 1'b1;
    return (({1'b0, i} + 1'b1) == len) ? '0 : inc;
  endfunction

  assign idx1 = next_idx(pos,  msg_len);
  assign idx2 = next_idx(idx1, msg_len);
  assign idx3 = next_idx(idx2, msg_len);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MSG_DEPTH; i++) mem[i] <= 5'h10;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_char;
    end
  end

  // Length load wins over a coincident terminal count and restarts the step.
  always_ff @(posedge clk) begin
    if (rst) begin
      msg_len     <= '0;
      pos         <= '0;
      cnt         <= '0;
      scroll_tick <= 1'b0;
    end else if (len_we) begin
      msg_len     <= (len_in > LEN_MAX) ? LEN_MAX : len_in;
      pos         <= '0;
      cnt         <= '0;
      scroll_tick <= 1'b0;
    end else if (run && (msg_len != '0)) begin
      if (cnt == CNT_END) begin
        cnt         <= '0;
        pos         <= next_idx(pos, msg_len);
        scroll_tick <= 1'b1;
      end else begin
        cnt         <= cnt + CNT_W'(1);
        scroll_tick <= 1'b0;
      end
    end else begin
      scroll_tick <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (msg_len == '0)) begin
      seg_bus <= '1;
    end else begin
      seg_bus <= {decode(mem[pos]), decode(mem[idx1]),
                  decode(mem[idx2]), decode(mem[idx3])};
    end
  end

endmodule

// File: tb/tb_scroll_msg_buffer.sv
// Scoreboard bench for scroll_msg_buffer: a queue-and-modulo reference model
// predicts each cycle's outputs, a monitor process compares them.
module tb_scroll_msg_buffer;

  localparam int TICK = 4;
  localparam int DEPTH = 16;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [4:0]  wr_char;
  logic        len_we;
  logic [4:0]  len_in;
  logic        run;
  logic [27:0] seg_bus;
  logic [3:0]  pos;
  logic        scroll_tick;

  scroll_msg_buffer #(.ADDR_W(4), .TICK_MAX(TICK)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
    .len_we(len_we), .len_in(len_in), .run(run),
    .seg_bus(seg_bus), .pos(pos), .scroll_tick(scroll_tick)
  );

  typedef struct packed {
    logic [27:0] seg;
    logic [3:0]  pos;
    logic        tick;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 0;

  logic [4:0] m_mem [DEPTH];
  int         m_len, m_pos, m_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [4:0] c);
    case (c)
      5'h00: return 7'b1000000;
      5'h01: return 7'b1111001;
      5'h02: return 7'b0100100;
      5'h03: return 7'b0110000;
      5'h04: return 7'b0011001;
      5'h05: return 7'b0010010;
      5'h06: return 7'b0000010;
      5'h07: return 7'b1111000;
      5'h08: return 7'b0000000;
      5'h09: return 7'b0010000;
      5'h0A: return 7'b0001000;
      5'h0B: return 7'b0000011;
      5'h0C: return 7'b1000110;
      5'h0D: return 7'b0100001;
      5'h0E: return 7'b0000110;
      5'h0F: return 7'b0001110;
      5'h11: return 7'b1000111;
      5'h12: return 7'b1000001;
      5'h13: return 7'b0001001;
      5'h14: return 7'b0001100;
      5'h15: return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  // Window k positions to the right of the leftmost digit shows char (pos+k) mod len.
  function automatic logic [27:0] render();
    logic [27:0] r;
    r = '1;
    if (m_len != 0)
      for (int k = 0; k < 4; k++)
        r[7*(3-k) +: 7] = seg_of(m_mem[(m_pos + k) % m_len]);
    return r;
  endfunction

  task automatic apply_stimulus(input bit r, input bit we, input logic [3:0] a,
                                input logic [4:0] ch, input bit lwe,
                                input logic [4:0] lin, input bit rn);
    exp_t e;
    @(negedge clk);
    rst = r; wr_en = we; wr_addr = a; wr_char = ch;
    len_we = lwe; len_in = lin; run = rn;
    e.tick = 1'b0;
    if (r) begin
      e.seg = '1;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 5'h10;
      m_len = 0; m_pos = 0; m_cnt = 0;
    end else begin
      e.seg = render();
      if (we) m_mem[a] = ch;
      if (lwe) begin
        m_len = (int'(lin) > DEPTH) ? DEPTH : int'(lin);
        m_pos = 0; m_cnt = 0;
      end else if (rn && m_len != 0) begin
        if (m_cnt == TICK - 1) begin
          m_cnt = 0;
          m_pos = (m_pos + 1) % m_len;
          e.tick = 1'b1;
        end else begin
          m_cnt++;
        end
      end
    end
    e.pos = 4'(m_pos);
    sb.push_back(e);
  endtask

  task automatic idle(input int n, input bit rn);
    for (int i = 0; i < n; i++) apply_stimulus(0, 0, 4'h0, 5'h0, 0, 5'h0, rn);
  endtask

  task automatic wait_terminal();
    while (m_cnt != TICK - 1) apply_stimulus(0, 0, 4'h0, 5'h0, 0, 5'h0, 1);
  endtask

  task automatic check_output(input string name, input logic [27:0] act,
                              input logic [27:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        for (int k = 0; k < 4; k++)
          check_output($sformatf("digit%0d", k), 28'(seg_bus[7*k +: 7]), 28'(e.seg[7*k +: 7]));
        check_output("pos", 28'(pos), 28'(e.pos));
        check_output("scroll_tick", 28'(scroll_tick), 28'(e.tick));
      end
    end
  end

  initial begin : stimulus
    rst = 1'b1; wr_en = 0; wr_addr = '0; wr_char = '0;
    len_we = 0; len_in = '0; run = 0;
    m_len = 0; m_pos = 0; m_cnt = 0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 5'h10;

    apply_stimulus(1, 0, 4'h0, 5'h0, 0, 5'h0, 0);
    idle(2, 0);

    // Frozen "ELU0" window.
    apply_stimulus(0, 1, 4'h0, 5'h0E, 0, 5'h0, 0);
    apply_stimulus(0, 1, 4'h1, 5'h11, 0, 5'h0, 0);
    apply_stimulus(0, 1, 4'h2, 5'h12, 0, 5'h0, 0);
    apply_stimulus(0, 1, 4'h3, 5'h00, 0, 5'h0, 0);
    apply_stimulus(0, 0, 4'h0, 5'h0, 1, 5'd4, 0);
    idle(20, 0);

    idle(20, 1);
    idle(3, 0);
    idle(6, 1);

    // Two-character message repeated across four digits.
    apply_stimulus(0, 1, 4'h0, 5'h01, 0, 5'h0, 1);
    apply_stimulus(0, 1, 4'h1, 5'h02, 0, 5'h0, 1);
    apply_stimulus(0, 0, 4'h0, 5'h0, 1, 5'd2, 1);
    idle(12, 1);
    apply_stimulus(0, 0, 4'h0, 5'h0, 1, 5'd1, 1);
    idle(6, 1);
    apply_stimulus(0, 0, 4'h0, 5'h0, 1, 5'd3, 1);
    idle(14, 1);

    // Oversized length load landing on the terminal count.
    wait_terminal();
    apply_stimulus(0, 0, 4'h0, 5'h0, 1, 5'd17, 1);
    idle(10, 1);

    // Write to the incoming slot on the advance edge, then reset mid-run.
    wait_terminal();
    apply_stimulus(0, 1, 4'((m_pos + 1) % m_len), 5'h13, 0, 5'h0, 1);
    idle(3, 1);
    apply_stimulus(1, 0, 4'h0, 5'h0, 0, 5'h0, 1);
    idle(6, 1);

    for (int i = 0; i < 400; i++) begin
      bit r, we, lwe, rn;
      r   = ($urandom_range(0, 149) == 0);
      we  = ($urandom_range(0, 9) < 3);
      lwe = ($urandom_range(0, 29) == 0);
      rn  = ($urandom_range(0, 9) < 8);
      apply_stimulus(r, we, 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)),
                     lwe, 5'($urandom_range(0, 31)), rn);
      if (m_len == 0 && $urandom_range(0, 3) == 0)
        apply_stimulus(0, 0, 4'h0, 5'h0, 1, 5'($urandom_range(1, 18)), 1);
    end

    stim_done = 1;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
